c1581_sd_arb: RTL

- Arbiter sharing one host SD block-transfer channel (sd_lba/sd_rd/sd_wr/sd_ack plus 512-byte buffer bus) among NDRIVES c1581_sd drive instances.
- Sits in the clk_sys domain between the drive instances and the system SD interface.
- Grants one drive at a time, round-robin. Forwards that drive's LBA and strobe to the host. Routes the ack and buffer signals back to that drive only.
- Holds the grant until the host transfer completes.

---
 rtl/c1581_pkg.sv | 13 +
 rtl/c1581_rr_pick.sv | 30 +++
 rtl/c1581_sd_arb.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/c1581_pkg.sv
// Shared types and constants for the c1581 SD channel arbiter.
package c1581_pkg;

    localparam int SD_LBA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/c1581_rr_pick.sv
// Combinational round-robin picker: first requester at or after rr_ptr_i, wrapping modulo NDRIVES.
module c1581_rr_pick
    import c1581_pkg::*;
#(
    parameter int NDRIVES = 4
) (
    input  logic [NDRIVES-1:0] req_i,
    input  logic [1:0]         rr_ptr_i,
    output logic               valid_o,
    output logic [1:0]         idx_o
);

    int   cand_s;
    logic hit_s;

    // Walk offsets from farthest to nearest so the nearest requester overwrites the rest.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = 2'd0;
        cand_s  = 0;
        hit_s   = 1'b0;
        for (int k = NDRIVES - 1; k >= 0; k--) begin
            cand_s  = (int'(rr_ptr_i) + k) % NDRIVES;
            hit_s   = |(req_i & (NDRIVES'(1'b1) << cand_s));
            valid_o = valid_o | hit_s;
            idx_o   = hit_s ? 2'(cand_s) : idx_o;
        end
    end

endmodule

// File: rtl/c1581_sd_arb.sv
// Round-robin arbiter sharing one host SD block channel among NDRIVES drives.
// Optional ack-wait timeout is compiled in with C1581_SD_ARB_TIMEOUT_EN.
module c1581_sd_arb
    import c1581_pkg::*;
#(
    parameter int NDRIVES = 4
`ifdef C1581_SD_ARB_TIMEOUT_EN
    ,
    parameter int TMO_W = 24
`endif
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic [32*NDRIVES-1:0]     drv_sd_lba,
    input  logic [NDRIVES-1:0]        drv_sd_rd,
    input  logic [NDRIVES-1:0]        drv_sd_wr,
    output logic [NDRIVES-1:0]        drv_sd_ack,
    input  logic [8*NDRIVES-1:0]      drv_sd_buff_din,
    output logic [NDRIVES-1:0]        drv_sd_buff_wr,
    output logic [SD_LBA_W-1:0]       sd_lba,
    output logic                      sd_rd,
    output logic                      sd_wr,
    input  logic                      sd_ack,
    input  logic                      sd_buff_wr,
    output logic [7:0]                sd_buff_din,
    output logic                      busy,
    output logic [1:0]                grant
);

    localparam int BYTE_W = 8;

    function automatic logic bit_at(input logic [NDRIVES-1:0] vec, input logic [1:0] idx);
        return |(vec & (NDRIVES'(1'b1) << idx));
    endfunction

    arb_state_t          state_q, state_d;
    logic [1:0]          grant_q, grant_d;
    logic [1:0]          rr_ptr_q, rr_ptr_d;
    logic [SD_LBA_W-1:0] sd_lba_q, sd_lba_d;
    logic                sd_rd_q, sd_rd_d;
    logic                sd_wr_q, sd_wr_d;

    logic [NDRIVES-1:0]  req_s;
    logic                pick_valid_s;
    logic [1:0]          pick_idx_s;
    logic                pick_rd_s;
    logic                pick_wr_s;
    logic [SD_LBA_W-1:0] pick_lba_s;
    logic                gnt_req_s;
    logic                ack_route_s;
    logic                bwr_route_s;
    logic                tmo_pulse_s;

`ifdef C1581_SD_ARB_TIMEOUT_EN
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic                tmo_pulse_q, tmo_pulse_d;
`endif

    assign req_s      = drv_sd_rd | drv_sd_wr;
    assign pick_rd_s  = bit_at(drv_sd_rd, pick_idx_s);
    assign pick_wr_s  = bit_at(drv_sd_wr, pick_idx_s);
    assign pick_lba_s = SD_LBA_W'(drv_sd_lba >> (SD_LBA_W * int'(pick_idx_s)));
    assign gnt_req_s  = bit_at(req_s, grant_q);

    c1581_rr_pick #(
        .NDRIVES (NDRIVES)
    ) u_pick (
        .req_i    (req_s),
        .rr_ptr_i (rr_ptr_q),
        .valid_o  (pick_valid_s),
        .idx_o    (pick_idx_s)
    );

`ifdef C1581_SD_ARB_TIMEOUT_EN
    assign tmo_pulse_s = tmo_pulse_q;
`else
    assign tmo_pulse_s = 1'b0;
`endif

    // Next-state and host request registers; grant and LBA only change when leaving IDLE.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        sd_lba_d = sd_lba_q;
        sd_rd_d  = sd_rd_q;
        sd_wr_d  = sd_wr_q;
`ifdef C1581_SD_ARB_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        tmo_pulse_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid_s) begin
                    grant_d  = pick_idx_s;
                    sd_lba_d = pick_lba_s;
                    sd_rd_d  = pick_rd_s;
                    sd_wr_d  = pick_wr_s & ~pick_rd_s;
                    state_d  = REQ;
`ifdef C1581_SD_ARB_TIMEOUT_EN
                    tmo_cnt_d = {TMO_W{1'b0}};
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (sd_ack) begin
                    sd_rd_d = 1'b0;
                    sd_wr_d = 1'b0;
                    state_d = XFER;
                end else if (!gnt_req_s) begin
                    sd_rd_d = 1'b0;
                    sd_wr_d = 1'b0;
                    state_d = DONE;
                end
`ifdef C1581_SD_ARB_TIMEOUT_EN
                else if (&tmo_cnt_q) begin
                    sd_rd_d     = 1'b0;
                    sd_wr_d     = 1'b0;
                    tmo_pulse_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
`else
                else begin
                    state_d = REQ;
                end
`endif
            end
            XFER: begin
                if (!sd_ack) begin
                    state_d = DONE;
                end else begin
                    state_d = XFER;
                end
            end
            DONE: begin
                rr_ptr_d = (grant_q == 2'(NDRIVES - 1)) ? 2'd0 : grant_q + 2'd1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and host-facing registers.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= 2'd0;
            rr_ptr_q <= 2'd0;
            sd_lba_q <= {SD_LBA_W{1'b0}};
            sd_rd_q  <= 1'b0;
            sd_wr_q  <= 1'b0;
`ifdef C1581_SD_ARB_TIMEOUT_EN
            tmo_cnt_q   <= {TMO_W{1'b0}};
            tmo_pulse_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            sd_lba_q <= sd_lba_d;
            sd_rd_q  <= sd_rd_d;
            sd_wr_q  <= sd_wr_d;
`ifdef C1581_SD_ARB_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            tmo_pulse_q <= tmo_pulse_d;
`endif
        end
    end

    // A timed-out request gets a one-cycle ack in DONE so the drive stops waiting.
    assign ack_route_s = (sd_ack & ((state_q == REQ) | (state_q == XFER))) | tmo_pulse_s;
    assign bwr_route_s = sd_buff_wr & (state_q == XFER);

    assign drv_sd_ack     = NDRIVES'(ack_route_s) << grant_q;
    assign drv_sd_buff_wr = NDRIVES'(bwr_route_s) << grant_q;
    assign sd_buff_din    = BYTE_W'(drv_sd_buff_din >> (BYTE_W * int'(grant_q)));

    assign sd_lba = sd_lba_q;
    assign sd_rd  = sd_rd_q;
    assign sd_wr  = sd_wr_q;
    assign busy   = (state_q != IDLE);
    assign grant  = grant_q;

endmodule
